// File: rtl/dm_store_pkg.sv
// rtl/dm_store_pkg.sv - shared opcodes, state encoding and lane constants for the store unit
package dm_store_pkg;

    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam int         LANE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

endpackage

// File: rtl/dm_store_unit_byte_merge.sv
// rtl/dm_store_unit_byte_merge.sv - replaces one little-endian byte lane of a word
module byte_merge
    import dm_store_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [1:0]        lane,
    input  logic [LANE_W-1:0] data_byte,
    output logic [31:0]       merged
);

    // Copy the word and overwrite only the addressed lane; lane n occupies bits 8n+7:8n
    always_comb begin
        merged = word;
        merged[{lane, 3'b000} +: LANE_W] = data_byte;
    end

endmodule

// File: rtl/dm_store_unit.sv
// rtl/dm_store_unit.sv - MEM-stage store path: single-cycle sw, two-cycle read-modify-write sb
module dm_store_unit
    import dm_store_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [5:0]    op,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          stall,
    output logic          done,
    output logic          misalign,
    output logic [CW-1:0] store_cnt
);

    state_t            state;
    logic [1:0]        lane_q;
    logic [LANE_W-1:0] byte_q;
    logic [AW-1:0]     waddr_q;
    logic [CW-1:0]     cnt_q;

    logic              is_sw;
    logic              is_sb;
    logic              aligned;
    logic [31:0]       merged;

    // Address bits above the memory window are intentionally ignored
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign is_sw   = req_valid && (op == OP_SW);
    assign is_sb   = req_valid && (op == OP_SB);
    assign aligned = (addr[1:0] == 2'b00);

    byte_merge u_merge (
        .word      (mem_rdata),
        .lane      (lane_q),
        .data_byte (byte_q),
        .merged    (merged)
    );

    // Memory strobes and pipeline handshakes; everything is held at zero while in reset
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        stall     = 1'b0;
        done      = 1'b0;
        misalign  = 1'b0;
        if (rst_n) begin
            if (state == ST_MERGE) begin
                mem_addr  = waddr_q;
                mem_we    = 1'b1;
                mem_wdata = merged;
                done      = 1'b1;
            end else begin
                mem_addr = addr[AW+1:2];
                if (is_sw) begin
                    if (aligned) begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata;
                        done      = 1'b1;
                    end else begin
                        misalign = 1'b1;
                    end
                end else if (is_sb) begin
                    stall = 1'b1;
                end
            end
        end
    end

    // Sequencer: an sb spends its first cycle reading the word, then merges and writes it back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lane_q  <= '0;
            byte_q  <= '0;
            waddr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_sb) begin
                        lane_q  <= addr[1:0];
                        byte_q  <= wdata[LANE_W-1:0];
                        waddr_q <= addr[AW+1:2];
                        state   <= ST_MERGE;
                    end
                end
                ST_MERGE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Retired-store counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign store_cnt = cnt_q;

endmodule

// File: tb/tb_dm_store_unit.sv
// tb/tb_dm_store_unit.sv - scoreboard bench for dm_store_unit with a word-memory reference model
module tb_dm_store_unit;
    import dm_store_pkg::*;

    localparam int AW = 10;
    localparam int CW = 4;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [5:0]    op;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic          stall;
    logic          done;
    logic          misalign;
    logic [CW-1:0] store_cnt;

    always #5 clk = ~clk;

    dm_store_unit #(.DW(32), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .done      (done),
        .misalign  (misalign),
        .store_cnt (store_cnt)
    );

    // Environment memory: synchronous read, no byte enables, plus a bench preload port
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic          we;
        logic [31:0]   wd;
        logic          st;
        logic          dn;
        logic          mis;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          exp_done = 0;
    logic [31:0] ref_mem [0:NW-1];
    int unsigned exp_cnt  = 0;

    // Monitor: every cycle the DUT presents its outputs, compare against the next expectation
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (q.size() > 0) begin
            e = q.pop_front();
            g = {mem_addr, mem_we, mem_wdata, stall, done, misalign, store_cnt};
            if (done === 1'b1) n_done++;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got addr=%h we=%b wd=%h stall=%b done=%b mis=%b cnt=%0d required addr=%h we=%b wd=%h stall=%b done=%b mis=%b cnt=%0d",
                         $time, g.a, g.we, g.wd, g.st, g.dn, g.mis, g.cnt,
                         e.a, e.we, e.wd, e.st, e.dn, e.mis, e.cnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic exp_t idle_exp(input logic [31:0] a);
        exp_t e;
        e     = '0;
        e.a   = a[AW+1:2];
        e.cnt = CW'(exp_cnt);
        return e;
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 2))
            0:       o = OP_SW;
            1:       o = OP_SB;
            default: o = 6'($urandom);
        endcase
        return o;
    endfunction

    // One request in IDLE; an sb also consumes the following merge cycle with junk inputs
    task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          w;
        int          sh;
        logic [31:0] nw;
        @(posedge clk); #1;
        pre_we = 1'b0;
        req_valid = v; op = o; addr = a; wdata = d;
        e = idle_exp(a);
        w = int'(a[AW+1:2]);
        if (v && o == OP_SW) begin
            if (a[1:0] == 2'b00) begin
                e.we = 1'b1; e.wd = d; e.dn = 1'b1;
                if (w < NW) ref_mem[w] = d;
                exp_cnt++; exp_done++;
            end else begin
                e.mis = 1'b1;
            end
            q.push_back(e);
        end else if (v && o == OP_SB) begin
            e.st = 1'b1;
            q.push_back(e);
            sh = 8 * int'(a[1:0]);
            nw = (ref_mem[w] & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
            @(posedge clk); #1;
            req_valid = 1'($urandom); op = rand_op(); addr = $urandom; wdata = $urandom;
            e = '0;
            e.a = a[AW+1:2]; e.we = 1'b1; e.wd = nw; e.dn = 1'b1; e.cnt = CW'(exp_cnt);
            ref_mem[w] = nw;
            exp_cnt++; exp_done++;
            q.push_back(e);
        end else begin
            q.push_back(e);
        end
    endtask

    // Idle cycle during which the bench writes a memory word directly
    task automatic poke(input int w, input logic [31:0] val);
        @(posedge clk); #1;
        req_valid = 1'b0; op = 6'h00; addr = 32'h0;
        pre_we = 1'b1; pre_addr = AW'(w); pre_data = val;
        ref_mem[w] = val;
        q.push_back(idle_exp(32'h0));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [5:0]  o;
        int          k;
        int          bad;
        rst_n = 1'b0; req_valid = 1'b0; op = 6'h00; addr = 32'h0; wdata = 32'h0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Preload the working window while reset holds the DUT quiet
        for (int i = 0; i < NW; i++) begin
            @(posedge clk); #1;
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = $urandom;
            ref_mem[i] = pre_data;
            req_valid = 1'($urandom); op = rand_op(); addr = $urandom;
            q.push_back('0);
        end
        @(posedge clk); #1;
        pre_we = 1'b0; rst_n = 1'b1; req_valid = 1'b0; addr = 32'h0;
        q.push_back(idle_exp(32'h0));

        // Aligned sw, then misaligned sw
        drive(1'b1, OP_SW, 32'h0000_0010, 32'hDEAD_BEEF);
        drive(1'b1, OP_SW, 32'h0000_0012, 32'h1234_5678);
        drive(1'b0, OP_SW, 32'h0000_0014, 32'h0BAD_0BAD);

        // sb into lane 2 of a known word
        poke(5, 32'h1122_3344);
        drive(1'b1, OP_SB, 32'h0000_0016, 32'h0000_00AB);
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        check("sb_lane2_word", mem[5], 32'h11AB_3344);

        // Back-to-back sb to one word
        poke(8, 32'h0000_0000);
        drive(1'b1, OP_SB, 32'h0000_0020, 32'h0000_0055);
        drive(1'b1, OP_SB, 32'h0000_0023, 32'h0000_0066);
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        check("b2b_sb_word", mem[8], 32'h6600_0055);

        // Reset asserted in the merge cycle drops the pending write
        poke(9, 32'hCAFE_F00D);
        @(posedge clk); #1;
        req_valid = 1'b1; op = OP_SB; addr = 32'h0000_0025; wdata = 32'h0000_0077;
        begin exp_t e; e = idle_exp(addr); e.st = 1'b1; q.push_back(e); end
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = 1'($urandom); op = rand_op(); addr = $urandom;
        exp_cnt = 0;
        q.push_back('0);
        @(posedge clk); #1;
        q.push_back('0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0; addr = 32'h0;
        q.push_back(idle_exp(32'h0));
        #2;
        check("reset_cnt", 32'(store_cnt), 32'h0);
        check("reset_dropped_word", mem[9], 32'hCAFE_F00D);

        // Sixteen aligned stores wrap the 4-bit counter
        for (int i = 0; i < 16; i++) drive(1'b1, OP_SW, 32'(4 * i), $urandom);
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        #2;
        check("cnt_wrap", 32'(store_cnt), 32'h0);

        // Randomised mix of stores, other opcodes and bubbles
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_F000) | ($urandom & 32'h0000_00FF);
            d = $urandom;
            if (k <= 3) begin
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                drive(1'b1, OP_SW, a, d);
            end else if (k <= 6) begin
                drive(1'b1, OP_SB, a, d);
            end else if (k == 7) begin
                drive(1'b0, ($urandom_range(0, 1) != 0) ? OP_SW : OP_SB, a, d);
            end else begin
                o = 6'($urandom);
                if (o == OP_SW || o == OP_SB) o = 6'h23;
                drive(1'b1, o, a, d);
            end
        end
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);

        check("queue_drained", 32'(q.size()), 32'h0);
        check("done_pulses", 32'(n_done), 32'(exp_done));
        bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("memory_image_mismatches", 32'(bad), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
